// File: rtl/register_status_issue_pkg.sv
// Shared types and constants for the issue stage and the reservation station.
//   NREG  : architectural register count (r0 reads as zero)
//   TAGW  : producer tag width; tag 0 (NO_TAG) means "value is in the regfile"
//   DATAW : data width
//   CTRLW : operation control width
package register_status_issue_pkg;
    localparam int NREG  = 32;
    localparam int TAGW  = 5;
    localparam int DATAW = 32;
    localparam int CTRLW = 6;
    localparam int REGW  = $clog2(NREG);
    localparam int NTAG  = 1 << TAGW;

    typedef logic [TAGW-1:0]  tag_t;
    typedef logic [DATAW-1:0] data_t;
    typedef logic [CTRLW-1:0] ctrl_t;
    typedef logic [REGW-1:0]  reg_idx_t;

    localparam tag_t NO_TAG = '0;

    // Resolved source operand as written into the reservation station.
    typedef struct packed {
        data_t val;
        logic  rdy;
        tag_t  tag;
    } src_res_t;
endpackage

// File: rtl/register_status_issue_if.sv
// Issue-side bundle: decoded instruction handshake, reservation station write
// port and result broadcast (CDB) snoop.
// Handshake: an instruction is consumed in every cycle where inst_valid and
// inst_ready are both high; inst_ready never depends on inst_valid.
//   slave  : the issue stage view
//   master : the decoder / reservation station / CDB environment view
interface register_status_issue_if;
    logic                             inst_valid;
    logic                             inst_ready;
    register_status_issue_pkg::reg_idx_t src1;
    register_status_issue_pkg::reg_idx_t src2;
    register_status_issue_pkg::reg_idx_t dst;
    logic                             has_dst;
    register_status_issue_pkg::ctrl_t ctrl;
    logic                             rs_full;
    logic                             rs_write;
    register_status_issue_pkg::data_t rs_val1;
    register_status_issue_pkg::data_t rs_val2;
    logic                             rs_val1_r;
    logic                             rs_val2_r;
    register_status_issue_pkg::tag_t  rs_tag1;
    register_status_issue_pkg::tag_t  rs_tag2;
    register_status_issue_pkg::tag_t  rs_dest_tag;
    register_status_issue_pkg::ctrl_t rs_ctrl;
    logic                             cdb_valid;
    register_status_issue_pkg::tag_t  cdb_tag;
    register_status_issue_pkg::data_t cdb_data;

    modport slave (
        input  inst_valid, src1, src2, dst, has_dst, ctrl, rs_full,
        input  cdb_valid, cdb_tag, cdb_data,
        output inst_ready, rs_write, rs_val1, rs_val2, rs_val1_r, rs_val2_r,
        output rs_tag1, rs_tag2, rs_dest_tag, rs_ctrl
    );

    modport master (
        output inst_valid, src1, src2, dst, has_dst, ctrl, rs_full,
        output cdb_valid, cdb_tag, cdb_data,
        input  inst_ready, rs_write, rs_val1, rs_val2, rs_val1_r, rs_val2_r,
        input  rs_tag1, rs_tag2, rs_dest_tag, rs_ctrl
    );
endinterface

// File: rtl/register_status_issue_tag_allocator.sv
// Producer tag allocator: free bitmap plus lowest-free priority encoder.
//   clk, rst   : clock, asynchronous active-low reset (all tags 1.. free)
//   alloc_en   : consume alloc_tag this cycle
//   free_en    : return free_tag this cycle (NO_TAG ignored)
//   alloc_tag  : lowest free tag from the registered bitmap, NO_TAG if none
//   tag_avail  : at least one tag is free
module register_status_issue_tag_allocator
    import register_status_issue_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic alloc_en,
    input  logic free_en,
    input  tag_t free_tag,
    output tag_t alloc_tag,
    output logic tag_avail
);
    logic [NTAG-1:0] free_q;
    logic [NTAG-1:0] free_d;

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        alloc_tag = NO_TAG;
        for (int t = NTAG - 1; t >= 1; t--) begin
            if (free_q[t]) alloc_tag = tag_t'(t);
        end
    end

    assign tag_avail = |free_q[NTAG-1:1];

    // Free before allocate: a broadcast of a tag that is not busy must not
    // undo an allocation of that same tag in the same cycle.
    always_comb begin
        free_d = free_q;
        if (free_en && free_tag != NO_TAG) free_d[free_tag] = 1'b1;
        if (alloc_en && tag_avail) free_d[alloc_tag] = 1'b0;
        free_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) free_q <= {{(NTAG-1){1'b1}}, 1'b0};
        else      free_q <= free_d;
    end
endmodule

// File: rtl/register_status_issue.sv
// Issue stage: architectural register file, per-register producer tag table
// and tag allocator. Resolves each source of the incoming instruction to a
// value or a pending tag and writes the reservation station in the same cycle;
// snoops the CDB to retire tags into the register file.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : instruction handshake, RS write port and CDB (slave view)
module register_status_issue
    import register_status_issue_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    register_status_issue_if.slave  bus
);
    data_t    regfile_q [NREG];
    data_t    regfile_d [NREG];
    tag_t     status_q  [NREG];
    tag_t     status_d  [NREG];

    logic     alloc_needed;
    logic     tag_avail;
    logic     issue;
    logic     cdb_hit;
    tag_t     alloc_tag;
    src_res_t res1;
    src_res_t res2;

    // Priority: r0, committed value, same-cycle CDB bypass, pending tag.
    function automatic src_res_t resolve(input reg_idx_t s, input tag_t st,
                                         input data_t rv, input logic hit,
                                         input tag_t ct, input data_t cd);
        src_res_t r;
        r = '{val: '0, rdy: 1'b1, tag: NO_TAG};
        if (s != '0) begin
            if (st == NO_TAG) begin
                r.val = rv;
            end else if (hit && ct == st) begin
                r.val = cd;
            end else begin
                r.rdy = 1'b0;
                r.tag = st;
            end
        end
        return r;
    endfunction

    assign alloc_needed = bus.has_dst && (bus.dst != '0);
    assign cdb_hit      = bus.cdb_valid && (bus.cdb_tag != NO_TAG);
    assign issue        = bus.inst_valid && bus.inst_ready;

    assign bus.inst_ready = !bus.rs_full && (tag_avail || !alloc_needed);
    assign bus.rs_write   = issue;

    // Sources always see pre-issue status, so src == dst reads the old producer.
    always_comb begin
        res1 = resolve(bus.src1, status_q[bus.src1], regfile_q[bus.src1],
                       cdb_hit, bus.cdb_tag, bus.cdb_data);
        res2 = resolve(bus.src2, status_q[bus.src2], regfile_q[bus.src2],
                       cdb_hit, bus.cdb_tag, bus.cdb_data);
    end

    assign bus.rs_val1     = res1.val;
    assign bus.rs_val1_r   = res1.rdy;
    assign bus.rs_tag1     = res1.tag;
    assign bus.rs_val2     = res2.val;
    assign bus.rs_val2_r   = res2.rdy;
    assign bus.rs_tag2     = res2.tag;
    assign bus.rs_dest_tag = alloc_needed ? alloc_tag : NO_TAG;
    assign bus.rs_ctrl     = bus.ctrl;

    // CDB retire first, then rename, so a new producer overrides the clear
    // of status[dst] while regfile[dst] still takes the broadcast value.
    always_comb begin
        regfile_d = regfile_q;
        status_d  = status_q;
        if (cdb_hit) begin
            for (int r = 0; r < NREG; r++) begin
                if (status_q[r] == bus.cdb_tag) begin
                    regfile_d[r] = bus.cdb_data;
                    status_d[r]  = NO_TAG;
                end
            end
        end
        if (issue && alloc_needed) status_d[bus.dst] = alloc_tag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regfile_q[r] <= '0;
                status_q[r]  <= NO_TAG;
            end
        end else begin
            regfile_q <= regfile_d;
            status_q  <= status_d;
        end
    end

    register_status_issue_tag_allocator u_tag_allocator (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (issue && alloc_needed),
        .free_en   (cdb_hit),
        .free_tag  (bus.cdb_tag),
        .alloc_tag (alloc_tag),
        .tag_avail (tag_avail)
    );
endmodule

// File: tb/tb_register_status_issue.sv
// Bench for register_status_issue: directed instruction/CDB vectors, a
// register-level model of regfile/status/busy tags checked on every falling
// edge, and hand-computed literal expectations at key points.
module tb_register_status_issue;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    register_status_issue_if bus ();

    register_status_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0] m_reg  [32];
    logic [4:0]  m_stat [32];
    bit          m_busy [32];

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_reg[r]  = '0;
            m_stat[r] = '0;
            m_busy[r] = 1'b0;
        end
    endfunction

    function automatic void m_src(input logic [4:0] s, output logic [31:0] v,
                                  output logic rdy, output logic [4:0] t);
        v = '0; rdy = 1'b1; t = '0;
        if (s == 0) begin
            v = '0;
        end else if (m_stat[s] == 0) begin
            v = m_reg[s];
        end else if (bus.cdb_valid && bus.cdb_tag != 0 && bus.cdb_tag == m_stat[s]) begin
            v = bus.cdb_data;
        end else begin
            rdy = 1'b0;
            t   = m_stat[s];
        end
    endfunction

    always @(negedge clk) begin
        logic        need;
        logic [4:0]  lowest;
        logic        e_ready;
        logic        e_write;
        logic [31:0] v1, v2;
        logic        r1, r2;
        logic [4:0]  t1, t2;
        if (!rst) model_reset();
        need   = bus.has_dst && bus.dst != 0;
        lowest = 0;
        for (int t = 1; t < 32; t++) if (!m_busy[t] && lowest == 0) lowest = 5'(t);
        e_ready = !bus.rs_full && (lowest != 0 || !need);
        e_write = bus.inst_valid && e_ready;
        m_src(bus.src1, v1, r1, t1);
        m_src(bus.src2, v2, r2, t2);
        chk("m_inst_ready", 32'(bus.inst_ready), 32'(e_ready));
        chk("m_rs_write", 32'(bus.rs_write), 32'(e_write));
        chk("m_val1", bus.rs_val1, v1);
        chk("m_val1_r", 32'(bus.rs_val1_r), 32'(r1));
        chk("m_tag1", 32'(bus.rs_tag1), 32'(t1));
        chk("m_val2", bus.rs_val2, v2);
        chk("m_val2_r", 32'(bus.rs_val2_r), 32'(r2));
        chk("m_tag2", 32'(bus.rs_tag2), 32'(t2));
        chk("m_dest_tag", 32'(bus.rs_dest_tag), need ? 32'(lowest) : 32'd0);
        chk("m_ctrl", 32'(bus.rs_ctrl), 32'(bus.ctrl));
        if (rst) begin
            if (bus.cdb_valid && bus.cdb_tag != 0 && m_busy[bus.cdb_tag]) begin
                for (int r = 0; r < 32; r++) begin
                    if (m_stat[r] == bus.cdb_tag) begin
                        m_reg[r]  = bus.cdb_data;
                        m_stat[r] = '0;
                    end
                end
                m_busy[bus.cdb_tag] = 1'b0;
            end
            if (e_write && need) begin
                m_stat[bus.dst] = lowest;
                m_busy[lowest]  = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic hd, input logic full,
                         input logic cv, input logic [4:0] ct, input logic [31:0] cd);
        bus.inst_valid = v;
        bus.src1       = s1;
        bus.src2       = s2;
        bus.dst        = d;
        bus.has_dst    = hd;
        bus.ctrl       = 6'(d + 5'(s1 << 1));
        bus.rs_full    = full;
        bus.cdb_valid  = cv;
        bus.cdb_tag    = ct;
        bus.cdb_data   = cd;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive(1, 1, 2, 3, 1, 0, 0, 0, 0);
        #1 rst = 1'b0;

        // reset state: outputs combinational from cleared state
        @(negedge clk);
        chk("reset_rs_write", 32'(bus.rs_write), 32'd1);
        chk("reset_dest_tag", 32'(bus.rs_dest_tag), 32'd1);

        // add r3 <- r1, r2
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("i1_write", 32'(bus.rs_write), 32'd1);
        chk("i1_val1_r", 32'(bus.rs_val1_r), 32'd1);
        chk("i1_val2_r", 32'(bus.rs_val2_r), 32'd1);
        chk("i1_val1", bus.rs_val1, 32'd0);
        chk("i1_dest", 32'(bus.rs_dest_tag), 32'd1);

        // r4 <- r3, r3
        tick(); drive(1, 3, 3, 4, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("i2_tag1", 32'(bus.rs_tag1), 32'd1);
        chk("i2_tag2", 32'(bus.rs_tag2), 32'd1);
        chk("i2_val1_r", 32'(bus.rs_val1_r), 32'd0);
        chk("i2_dest", 32'(bus.rs_dest_tag), 32'd2);

        // r5 <- r3, r4 with CDB tag 1 = 0x55 (bypass)
        tick(); drive(1, 3, 4, 5, 1, 0, 1, 1, 32'h55);
        @(negedge clk);
        chk("i3_val1", bus.rs_val1, 32'h55);
        chk("i3_val1_r", 32'(bus.rs_val1_r), 32'd1);
        chk("i3_tag2", 32'(bus.rs_tag2), 32'd2);
        chk("i3_dest", 32'(bus.rs_dest_tag), 32'd3);

        // r7 <- r3, r0: regfile[3] committed, tag 1 reallocated
        tick(); drive(1, 3, 0, 7, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("i4_val1", bus.rs_val1, 32'h55);
        chk("i4_tag1", 32'(bus.rs_tag1), 32'd0);
        chk("i4_dest", 32'(bus.rs_dest_tag), 32'd1);

        // rs_full blocks issue
        tick(); drive(1, 7, 0, 8, 1, 1, 0, 0, 0);
        @(negedge clk);
        chk("full_ready", 32'(bus.inst_ready), 32'd0);
        chk("full_write", 32'(bus.rs_write), 32'd0);
        tick(); drive(1, 8, 7, 9, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("after_full_val1_r", 32'(bus.rs_val1_r), 32'd1);
        chk("after_full_tag2", 32'(bus.rs_tag2), 32'd1);
        chk("after_full_dest", 32'(bus.rs_dest_tag), 32'd4);

        // rename r6 while CDB retires its old producer
        tick(); drive(1, 0, 0, 6, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("r6a_dest", 32'(bus.rs_dest_tag), 32'd5);
        tick(); drive(1, 6, 0, 6, 1, 0, 1, 5, 32'hA6);
        @(negedge clk);
        chk("r6b_val1", bus.rs_val1, 32'hA6);
        chk("r6b_dest", 32'(bus.rs_dest_tag), 32'd6);
        tick(); drive(1, 6, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r6c_tag1", 32'(bus.rs_tag1), 32'd6);
        chk("r6c_val1_r", 32'(bus.rs_val1_r), 32'd0);

        // mid-stream asynchronous reset
        tick(); drive(1, 4, 5, 12, 1, 0, 0, 0, 0); rst = 1'b0;
        #1;
        chk("areset_tag1", 32'(bus.rs_tag1), 32'd0);
        chk("areset_dest", 32'(bus.rs_dest_tag), 32'd1);
        @(negedge clk);
        chk("areset_write", 32'(bus.rs_write), 32'd1);
        tick(); rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // exhaust all 31 tags
        for (int i = 0; i < 31; i++) begin
            tick(); drive(1, 0, 0, 5'(i + 1), 1, 0, 0, 0, 0);
            @(negedge clk);
            chk("fill_dest", 32'(bus.rs_dest_tag), 32'(i + 1));
        end
        tick(); drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("stall_ready", 32'(bus.inst_ready), 32'd0);
        chk("stall_write", 32'(bus.rs_write), 32'd0);
        tick(); drive(1, 9, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("nodst_write", 32'(bus.rs_write), 32'd1);
        chk("nodst_tag1", 32'(bus.rs_tag1), 32'd9);
        tick(); drive(1, 0, 0, 1, 1, 0, 1, 7, 32'h77);
        @(negedge clk);
        chk("free_same_cycle_ready", 32'(bus.inst_ready), 32'd0);
        tick(); drive(1, 7, 20, 20, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("realloc_dest", 32'(bus.rs_dest_tag), 32'd7);
        chk("realloc_write", 32'(bus.rs_write), 32'd1);
        chk("realloc_val1", bus.rs_val1, 32'h77);
        chk("realloc_tag2", 32'(bus.rs_tag2), 32'd20);

        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/register_status_issue.md
# register_status_issue

Issue stage for the out-of-order core. Holds the architectural register file, the per-register status (producer tag) table and the tag allocator. It accepts one decoded instruction per cycle and resolves each source to a value or a pending tag. It drives the reservation station's write port (val1/val1_r/rs_tag, val2/val2_r/rt_tag, dest_tag, control) and snoops the result broadcast bus (CDB) to retire tags into the register file.

## Interface
- NREG, 32, architectural registers (r0 hardwired zero)
- TAGW, 5, tag width; tag 0 = NO_TAG, tags 1..2^TAGW-1 allocatable
- DATAW, 32, data width
- CTRLW, 6, control field width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock, asynchronous, active-low
- inst_valid  in  1  decoded instruction present
- inst_ready  out  1  instruction accepted this cycle when inst_valid & inst_ready
- src1, src2  in  5  architectural source registers
- dst  in  5  architectural destination
- has_dst  in  1  instruction writes dst
- ctrl  in  CTRLW  operation control, passed through
- rs_full  in  1  reservation station full
- rs_write  out  1  write strobe to reservation station
- rs_val1, rs_val2  out  DATAW  source values (0 when not ready)
- rs_val1_r, rs_val2_r  out  1  source value valid
- rs_tag1, rs_tag2  out  TAGW  producer tag when not ready, else 0
- rs_dest_tag  out  TAGW  allocated tag, 0 if none
- rs_ctrl  out  CTRLW  = ctrl
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAGW  broadcast tag (0 ignored)
- cdb_data  in  DATAW  broadcast value

## Operation
- alloc_needed = has_dst & (dst != 0); tag_avail = any free tag.
- inst_ready = ~rs_full & (tag_avail | ~alloc_needed); combinational, independent of inst_valid.
- rs_write = inst_valid & inst_ready; all rs_* outputs combinational from current state + inputs.
- Source resolution for s in {src1, src2}, in priority order:
  - s == 0 → value 0, ready.
  - status[s] == 0 → regfile[s], ready.
  - cdb_valid & cdb_tag != 0 & cdb_tag == status[s] → cdb_data, ready (same-cycle bypass).
  - Otherwise → value 0, not ready, tag = status[s].
- Sources use pre-issue status; src == dst reads the old producer.
- Allocation: lowest-numbered free tag; on accept with alloc_needed, status[dst] <= tag and the tag is marked busy.
- CDB (cdb_valid, cdb_tag != 0): free[cdb_tag] <= 1. For every r with status[r] == cdb_tag: regfile[r] <= cdb_data and status[r] <= 0.
- A CDB tag that is not currently busy is ignored (no state change).

## Timing
- Issue has 0-cycle latency: rs_write and rs_* are valid in the accepting cycle. Status and free-list updates are visible the next cycle.
- CDB writeback to the register file and status takes 1 cycle. Same-cycle readers get the value via the bypass.
- Simultaneous issue renaming dst and CDB clearing status[dst]: the new tag wins in status, and regfile[dst] is still written.
- Simultaneous CDB freeing tag t and allocation: the allocator sees the registered free list, so t becomes allocatable next cycle.
- rs_full = 1: inst_ready = 0, rs_write = 0, no state change.
- All tags busy: instructions with alloc_needed stall; instructions without a destination still issue.
- Reset (async, mid-operation included): regfile all 0, status all 0, all allocatable tags free. Outputs take their combinational values from the reset state: rs_write = inst_valid & ~rs_full, rs_dest_tag = lowest free tag (1) when alloc_needed.

## Structure
- Shared package: TAGW, DATAW, CTRLW, NREG, NO_TAG = 0, typedefs tag_t, data_t, ctrl_t. The reservation station uses the same package.
- Sub-module tag_allocator: free bitmap plus lowest-free priority encoder; alloc/free ports, tag_avail out.
- Register file and status table are flat arrays in the top; no separate module.

## Test plan
- After reset, issue add r3 ← r1, r2 → rs_write = 1, val1_r = val2_r = 1, values 0, rs_dest_tag = 1; next cycle status[3] = 1.
- Next cycle, issue r4 ← r3, r3 → rs_tag1 = rs_tag2 = 1, val_r = 0, rs_dest_tag = 2.
- CDB tag 1 data 0x55 in the same cycle as issuing r5 ← r3 → rs_val1 = 0x55, val1_r = 1. Next cycle regfile[3] = 0x55 and status[3] = 0. Tag 1 is reallocated on the next issue.
- rs_full = 1 with inst_valid = 1 → inst_ready = 0, rs_write = 0, no tag consumed, status unchanged.
- 31 back-to-back issues with no CDB → 32nd (has_dst) stalls, has_dst = 0 instruction still issues. CDB tag 7 → the following cycle allocates tag 7.
- Issue r6 ← … while CDB retires the old producer of r6 → status[6] = new tag, regfile[6] = CDB data. Then drop rst mid-stream → status, regfile and free list cleared immediately.
